rocc_cmd_queue: RTL

Parametrised RoCC command/response adapter between the issue stage and an external RoCC accelerator. It buffers up to CMD_DEPTH commands and tracks up to MAX_OUTSTANDING in-flight transactions, so issue is not stalled by a single busy accelerator cycle. Responses are matched in order to stored trans_ids and written back one cycle after arrival. Flush drops queued commands and discards late responses to commands already sent.

---
 rtl/rocc_cmd_queue.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/rocc_cmd_queue.sv
// rocc_cmd_queue: RoCC command FIFO plus in-order tag scoreboard with flush drop accounting.
// Optional macro ROCC_CMD_BYPASS_EN adds a 0-cycle issue->cmd path when the command FIFO is empty.
module rocc_cmd_queue #(
  parameter int XLEN            = 64,
  parameter int TRANS_ID_W      = 3,
  parameter int CMD_DEPTH       = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  issue_valid_i,
  output logic                  issue_ready_o,
  input  logic [XLEN-1:0]       issue_rs1_i,
  input  logic [XLEN-1:0]       issue_rs2_i,
  input  logic [31:0]           issue_instr_i,
  input  logic [TRANS_ID_W-1:0] issue_trans_id_i,
  output logic                  cmd_valid_o,
  input  logic                  cmd_ready_i,
  output logic [XLEN-1:0]       cmd_rs1_o,
  output logic [XLEN-1:0]       cmd_rs2_o,
  output logic [31:0]           cmd_instr_o,
  input  logic                  resp_valid_i,
  output logic                  resp_ready_o,
  input  logic [XLEN-1:0]       resp_data_i,
  output logic                  wb_valid_o,
  output logic [TRANS_ID_W-1:0] wb_trans_id_o,
  output logic [XLEN-1:0]       wb_result_o,
  output logic                  wb_exception_valid_o,
  output logic                  busy_o,
  output logic                  err_spurious_o
);

  localparam int CMD_AW = $clog2(CMD_DEPTH);
  localparam int CMD_CW = $clog2(CMD_DEPTH + 1);
  localparam int TAG_AW = $clog2(MAX_OUTSTANDING);
  localparam int TAG_CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int ENT_W  = 2 * XLEN + 32;

  logic [ENT_W-1:0]      cmd_mem_q [CMD_DEPTH];
  logic [ENT_W-1:0]      cmd_mem_d [CMD_DEPTH];
  logic [CMD_AW-1:0]     cmd_wr_q, cmd_wr_d, cmd_rd_q, cmd_rd_d;
  logic [CMD_CW-1:0]     cmd_cnt_q, cmd_cnt_d;
  logic [TRANS_ID_W-1:0] tag_mem_q [MAX_OUTSTANDING];
  logic [TRANS_ID_W-1:0] tag_mem_d [MAX_OUTSTANDING];
  logic [TAG_AW-1:0]     tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [TAG_CW-1:0]     tag_cnt_q, tag_cnt_d;
  logic [TAG_CW-1:0]     drop_q, drop_d;
  logic                  wb_valid_q, wb_valid_d;
  logic [TRANS_ID_W-1:0] wb_id_q, wb_id_d;
  logic [XLEN-1:0]       wb_res_q, wb_res_d;
  logic                  err_q, err_d;

  logic              cmd_empty, issue_fire, cmd_push, cmd_pop, tag_pop;
  logic [ENT_W-1:0]  issue_entry, head_entry;
  logic [TAG_CW:0]   inflight_sum;
  logic [TAG_CW-1:0] cmd_left, sent_cnt, pending_drop;

  assign cmd_empty    = (cmd_cnt_q == '0);
  assign issue_entry  = {issue_rs1_i, issue_rs2_i, issue_instr_i};
  assign head_entry   = cmd_mem_q[cmd_rd_q];
  assign inflight_sum = {1'b0, tag_cnt_q} + {1'b0, drop_q};

  // Pending drops reserve scoreboard slots so late responses can never alias a new tag.
  assign issue_ready_o = ~rst_i & ~flush_i
                       & (cmd_cnt_q < CMD_CW'(CMD_DEPTH))
                       & (inflight_sum < (TAG_CW + 1)'(MAX_OUTSTANDING));
  assign issue_fire    = issue_valid_i & issue_ready_o;
  assign cmd_pop       = ~cmd_empty & cmd_ready_i;

`ifdef ROCC_CMD_BYPASS_EN
  logic bypass;
  assign bypass      = issue_fire & cmd_empty;
  assign cmd_valid_o = ~cmd_empty | bypass;
  assign {cmd_rs1_o, cmd_rs2_o, cmd_instr_o} = bypass ? issue_entry : head_entry;
  assign cmd_push    = issue_fire & ~(bypass & cmd_ready_i);
`else
  assign cmd_valid_o = ~cmd_empty;
  assign {cmd_rs1_o, cmd_rs2_o, cmd_instr_o} = head_entry;
  assign cmd_push    = issue_fire;
`endif

  always_comb begin
    cmd_mem_d  = cmd_mem_q;
    cmd_wr_d   = cmd_wr_q;
    cmd_rd_d   = cmd_rd_q;
    tag_mem_d  = tag_mem_q;
    tag_wr_d   = tag_wr_q;
    tag_rd_d   = tag_rd_q;
    drop_d     = drop_q;
    err_d      = err_q;
    wb_valid_d = 1'b0;
    wb_id_d    = wb_id_q;
    wb_res_d   = wb_res_q;
    tag_pop    = 1'b0;

    // A head popped during the flush cycle has reached the accelerator, so it counts as sent.
    cmd_left     = TAG_CW'(cmd_cnt_q) - TAG_CW'(cmd_pop);
    sent_cnt     = tag_cnt_q - cmd_left;
    pending_drop = drop_q + sent_cnt;

    if (cmd_push) begin
      cmd_mem_d[cmd_wr_q] = issue_entry;
      cmd_wr_d            = cmd_wr_q + CMD_AW'(1);
    end
    if (cmd_pop)
      cmd_rd_d = cmd_rd_q + CMD_AW'(1);
    if (issue_fire) begin
      tag_mem_d[tag_wr_q] = issue_trans_id_i;
      tag_wr_d            = tag_wr_q + TAG_AW'(1);
    end

    if (flush_i) begin
      if (pending_drop != '0)
        drop_d = pending_drop - TAG_CW'(resp_valid_i);
      else if (resp_valid_i)
        err_d = 1'b1;
    end else if (resp_valid_i) begin
      if (drop_q != '0) begin
        drop_d = drop_q - TAG_CW'(1);
      end else if (tag_cnt_q != '0) begin
        tag_pop    = 1'b1;
        wb_valid_d = 1'b1;
        wb_id_d    = tag_mem_q[tag_rd_q];
        wb_res_d   = resp_data_i;
      end else begin
        err_d = 1'b1;
      end
    end
    if (tag_pop)
      tag_rd_d = tag_rd_q + TAG_AW'(1);

    cmd_cnt_d = cmd_cnt_q + CMD_CW'(cmd_push) - CMD_CW'(cmd_pop);
    tag_cnt_d = tag_cnt_q + TAG_CW'(issue_fire) - TAG_CW'(tag_pop);

    if (flush_i) begin
      cmd_wr_d  = '0;
      cmd_rd_d  = '0;
      cmd_cnt_d = '0;
      tag_wr_d  = '0;
      tag_rd_d  = '0;
      tag_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cmd_wr_q   <= '0;
      cmd_rd_q   <= '0;
      cmd_cnt_q  <= '0;
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
      tag_cnt_q  <= '0;
      drop_q     <= '0;
      err_q      <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_id_q    <= '0;
      wb_res_q   <= '0;
    end else begin
      cmd_wr_q   <= cmd_wr_d;
      cmd_rd_q   <= cmd_rd_d;
      cmd_cnt_q  <= cmd_cnt_d;
      tag_wr_q   <= tag_wr_d;
      tag_rd_q   <= tag_rd_d;
      tag_cnt_q  <= tag_cnt_d;
      drop_q     <= drop_d;
      err_q      <= err_d;
      wb_valid_q <= wb_valid_d;
      wb_id_q    <= wb_id_d;
      wb_res_q   <= wb_res_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the counters above.
  always_ff @(posedge clk_i) begin
    cmd_mem_q <= cmd_mem_d;
    tag_mem_q <= tag_mem_d;
  end

  assign resp_ready_o         = 1'b1;
  assign wb_valid_o           = wb_valid_q;
  assign wb_trans_id_o        = wb_id_q;
  assign wb_result_o          = wb_res_q;
  assign wb_exception_valid_o = 1'b0;
  assign busy_o               = ~cmd_empty | (tag_cnt_q != '0) | (drop_q != '0);
  assign err_spurious_o       = err_q;

endmodule
